// File: rtl/drive_update_scheduler.sv
// ============================================================================
// drive_update_scheduler
//
// Time-multiplexed update controller for the three drive registers of the
// emotional model (energy, stress, pleasure). A model tick latches the
// regulators' inc/dec/setval requests. The scheduler then walks the three
// drives one per cycle through a single shared saturating add/subtract unit.
//
// Ports
//   clk      in   1  single clock, rising edge
//   rst      in   1  synchronous, active-high reset
//   tick     in   1  model-tick pulse, starts an update sequence
//   inc      in   3  increment requests (bit0 energy, bit1 stress, bit2 pleasure)
//   dec      in   3  decrement requests (same mapping as inc)
//   setval   in   1  load SET_VAL into every drive on this tick
//   energy   out  N  energy register
//   stress   out  N  stress register
//   pleasure out  N  pleasure register
//   busy     out  1  high whenever the sequencer is not idle
//   done     out  1  one-cycle pulse after all three drives are updated
//   slot     out  2  drive being updated (0/1/2), 3 when none
//   overrun  out  1  sticky: a tick arrived mid-sequence
// ============================================================================
module drive_update_scheduler #(
    parameter int N       = 7,
    parameter int STEP    = 1,
    parameter int DEF_EN  = 96,
    parameter int DEF_ST  = 40,
    parameter int DEF_PL  = 64,
    parameter int SET_VAL = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [2:0]   inc,
    input  logic [2:0]   dec,
    input  logic         setval,
    output logic [N-1:0] energy,
    output logic [N-1:0] stress,
    output logic [N-1:0] pleasure,
    output logic         busy,
    output logic         done,
    output logic [1:0]   slot,
    output logic         overrun
);

    typedef enum logic [2:0] {
        IDLE,
        UPD_EN,
        UPD_ST,
        UPD_PL,
        DONE
    } state_t;

    localparam logic [N:0]   MAX_W    = (N+1)'((1 << N) - 1);
    localparam logic [N:0]   STEP_W   = (N+1)'(STEP);
    localparam logic [N-1:0] STEP_N   = N'(STEP);
    localparam logic [N-1:0] MAX_N    = N'((1 << N) - 1);
    localparam logic [N-1:0] SET_N    = N'(SET_VAL);
    localparam logic [N-1:0] DEF_EN_N = N'(DEF_EN);
    localparam logic [N-1:0] DEF_ST_N = N'(DEF_ST);
    localparam logic [N-1:0] DEF_PL_N = N'(DEF_PL);

    state_t       state;
    state_t       next_state;

    logic [2:0]   inc_q;
    logic [2:0]   dec_q;
    logic         setval_q;

    logic         accept;
    logic         mid_seq;

    logic [N-1:0] operand;
    logic         sel_inc;
    logic         sel_dec;
    logic [N:0]   sum;
    logic [N-1:0] result;

    // A tick is accepted in IDLE and also in the DONE cycle. Accepting it in
    // DONE is what allows back-to-back sequences every four cycles: the done
    // pulse for the old sequence still appears while the new one is latched.
    // Any tick seen while a drive is being updated is an overrun.
    always_comb begin
        mid_seq = (state == UPD_EN) || (state == UPD_ST) || (state == UPD_PL);
        accept  = tick && ((state == IDLE) || (state == DONE));
    end

    // Next-state logic. The three update states advance unconditionally, so
    // a sequence always takes exactly four cycles once started.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = tick ? UPD_EN : IDLE;
            UPD_EN:  next_state = UPD_ST;
            UPD_ST:  next_state = UPD_PL;
            UPD_PL:  next_state = DONE;
            DONE:    next_state = tick ? UPD_EN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Shared arithmetic unit. The slot multiplexer picks which register and
    // which latched request bits feed the single adder/subtractor. The sum is
    // formed one bit wider so that an overflow past MAX is visible and can
    // be clamped. Subtraction clamps at zero before it can wrap.
    always_comb begin
        operand = energy;
        sel_inc = inc_q[0];
        sel_dec = dec_q[0];
        case (state)
            UPD_ST: begin
                operand = stress;
                sel_inc = inc_q[1];
                sel_dec = dec_q[1];
            end
            UPD_PL: begin
                operand = pleasure;
                sel_inc = inc_q[2];
                sel_dec = dec_q[2];
            end
            default: begin
                operand = energy;
                sel_inc = inc_q[0];
                sel_dec = dec_q[0];
            end
        endcase

        sum    = {1'b0, operand} + STEP_W;
        result = operand;
        if (setval_q) begin
            result = SET_N;
        end else if (sel_inc && !sel_dec) begin
            result = (sum > MAX_W) ? MAX_N : sum[N-1:0];
        end else if (sel_dec && !sel_inc) begin
            result = ({1'b0, operand} < STEP_W) ? '0 : (operand - STEP_N);
        end
    end

    // State, request latches, drive registers and registered status outputs.
    // Reset overrides everything, so a sequence cut short by reset restores
    // every drive to its default, including drives already written. The
    // status outputs are computed from next_state so that they line up with
    // the state register while still being driven from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            inc_q    <= '0;
            dec_q    <= '0;
            setval_q <= 1'b0;
            energy   <= DEF_EN_N;
            stress   <= DEF_ST_N;
            pleasure <= DEF_PL_N;
            busy     <= 1'b0;
            done     <= 1'b0;
            slot     <= 2'd3;
            overrun  <= 1'b0;
        end else begin
            state <= next_state;

            if (accept) begin
                inc_q    <= inc;
                dec_q    <= dec;
                setval_q <= setval;
            end

            if (state == UPD_EN) begin
                energy <= result;
            end
            if (state == UPD_ST) begin
                stress <= result;
            end
            if (state == UPD_PL) begin
                pleasure <= result;
            end

            if (tick && mid_seq) begin
                overrun <= 1'b1;
            end

            busy <= (next_state != IDLE);
            done <= (next_state == DONE);
            case (next_state)
                UPD_EN:  slot <= 2'd0;
                UPD_ST:  slot <= 2'd1;
                UPD_PL:  slot <= 2'd2;
                default: slot <= 2'd3;
            endcase
        end
    end

endmodule

// File: tb/tb_drive_update_scheduler.sv
// ============================================================================
// tb_drive_update_scheduler
//
// Directed bench for drive_update_scheduler. Two instances share one set of
// inputs: "m" uses the default parameters (STEP=1), and "s" uses STEP=4
// with defaults 125/2/64 so that the saturation edges are reached on the
// first ticks. Expected values are hand-computed constants.
// ============================================================================
module tb_drive_update_scheduler;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [2:0] inc;
    logic [2:0] dec;
    logic       setval;

    logic [6:0] m_energy, m_stress, m_pleasure;
    logic       m_busy, m_done, m_overrun;
    logic [1:0] m_slot;

    logic [6:0] s_energy, s_stress, s_pleasure;
    logic       s_busy, s_done, s_overrun;
    logic [1:0] s_slot;

    int errors;
    int checks;

    drive_update_scheduler m_dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .inc      (inc),
        .dec      (dec),
        .setval   (setval),
        .energy   (m_energy),
        .stress   (m_stress),
        .pleasure (m_pleasure),
        .busy     (m_busy),
        .done     (m_done),
        .slot     (m_slot),
        .overrun  (m_overrun)
    );

    drive_update_scheduler #(
        .STEP   (4),
        .DEF_EN (125),
        .DEF_ST (2)
    ) s_dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .inc      (inc),
        .dec      (dec),
        .setval   (setval),
        .energy   (s_energy),
        .stress   (s_stress),
        .pleasure (s_pleasure),
        .busy     (s_busy),
        .done     (s_done),
        .slot     (s_slot),
        .overrun  (s_overrun)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One full sequence: tick with the given requests at edge k, inputs
    // cleared right after, and return just after edge k+4 (back in IDLE).
    task automatic applyStimulus(input logic [2:0] i, input logic [2:0] d, input logic s);
        tick   = 1'b1;
        inc    = i;
        dec    = d;
        setval = s;
        stepCycle();
        tick   = 1'b0;
        inc    = 3'b000;
        dec    = 3'b000;
        setval = 1'b0;
        repeat (4) stepCycle();
    endtask

    // Checks all three main-instance drives at once.
    task automatic checkDrives(input string tag, input int e, input int st, input int p);
        checkOutput({tag, ".energy"},   int'(m_energy),   e);
        checkOutput({tag, ".stress"},   int'(m_stress),   st);
        checkOutput({tag, ".pleasure"}, int'(m_pleasure), p);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        tick   = 1'b0;
        inc    = 3'b000;
        dec    = 3'b000;
        setval = 1'b0;

        // Reset values
        repeat (2) stepCycle();
        rst = 1'b0;
        checkDrives("reset", 96, 40, 64);
        checkOutput("reset.busy", int'(m_busy), 0);
        checkOutput("reset.slot", int'(m_slot), 3);
        checkOutput("reset.overrun", int'(m_overrun), 0);
        checkOutput("reset.done", int'(m_done), 0);
        checkOutput("reset.s_energy", int'(s_energy), 125);
        checkOutput("reset.s_stress", int'(s_stress), 2);
        repeat (20) stepCycle();
        checkDrives("quiet", 96, 40, 64);
        checkOutput("quiet.slot", int'(m_slot), 3);
        checkOutput("quiet.busy", int'(m_busy), 0);

        // Single increment, cycle by cycle
        tick = 1'b1;
        inc  = 3'b001;
        stepCycle();
        tick = 1'b0;
        inc  = 3'b000;
        checkOutput("seq.k.busy", int'(m_busy), 1);
        checkOutput("seq.k.slot", int'(m_slot), 0);
        checkOutput("seq.k.energy", int'(m_energy), 96);
        checkOutput("seq.k.done", int'(m_done), 0);
        stepCycle();
        checkOutput("seq.k1.energy", int'(m_energy), 97);
        checkOutput("seq.k1.slot", int'(m_slot), 1);
        stepCycle();
        checkOutput("seq.k2.slot", int'(m_slot), 2);
        checkOutput("seq.k2.done", int'(m_done), 0);
        stepCycle();
        checkOutput("seq.k3.slot", int'(m_slot), 3);
        checkOutput("seq.k3.done", int'(m_done), 1);
        checkOutput("seq.k3.busy", int'(m_busy), 1);
        stepCycle();
        checkOutput("seq.k4.done", int'(m_done), 0);
        checkOutput("seq.k4.busy", int'(m_busy), 0);
        checkDrives("seq.k4", 97, 40, 64);
        checkOutput("sat.inc.s_energy", int'(s_energy), 127);

        // Saturation on the STEP=4 instance, normal steps on the main one
        applyStimulus(3'b001, 3'b010, 1'b0);
        checkDrives("mix1", 98, 39, 64);
        checkOutput("sat1.s_energy", int'(s_energy), 127);
        checkOutput("sat1.s_stress", int'(s_stress), 0);
        applyStimulus(3'b001, 3'b010, 1'b0);
        checkDrives("mix2", 99, 38, 64);
        checkOutput("sat2.s_energy", int'(s_energy), 127);
        checkOutput("sat2.s_stress", int'(s_stress), 0);

        // Conflict and setval
        applyStimulus(3'b111, 3'b111, 1'b0);
        checkDrives("conflict", 99, 38, 64);
        checkOutput("conflict.s_energy", int'(s_energy), 127);
        applyStimulus(3'b111, 3'b000, 1'b1);
        checkDrives("setval", 64, 64, 64);
        checkOutput("setval.s_energy", int'(s_energy), 64);
        checkOutput("setval.s_stress", int'(s_stress), 0 + 64);

        // Overrun: ticks at k, k+2 (ignored) and k+4 (accepted)
        tick = 1'b1;
        inc  = 3'b001;
        stepCycle();
        tick = 1'b0;
        inc  = 3'b000;
        stepCycle();
        checkOutput("ovr.k1.energy", int'(m_energy), 65);
        checkOutput("ovr.k1.overrun", int'(m_overrun), 0);
        tick = 1'b1;
        stepCycle();
        tick = 1'b0;
        checkOutput("ovr.k2.overrun", int'(m_overrun), 1);
        checkOutput("ovr.k2.slot", int'(m_slot), 2);
        stepCycle();
        checkOutput("ovr.k3.done", int'(m_done), 1);
        tick = 1'b1;
        inc  = 3'b010;
        stepCycle();
        tick = 1'b0;
        inc  = 3'b000;
        checkOutput("ovr.k4.slot", int'(m_slot), 0);
        checkOutput("ovr.k4.busy", int'(m_busy), 1);
        checkOutput("ovr.k4.done", int'(m_done), 0);
        checkOutput("ovr.k4.overrun", int'(m_overrun), 1);
        repeat (4) stepCycle();
        checkDrives("ovr.end", 65, 65, 64);
        checkOutput("ovr.end.busy", int'(m_busy), 0);
        checkOutput("ovr.end.overrun", int'(m_overrun), 1);

        // Reset mid-sequence
        tick = 1'b1;
        inc  = 3'b111;
        stepCycle();
        tick = 1'b0;
        inc  = 3'b000;
        stepCycle();
        checkOutput("rstmid.k1.energy", int'(m_energy), 66);
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        checkDrives("rstmid", 96, 40, 64);
        checkOutput("rstmid.busy", int'(m_busy), 0);
        checkOutput("rstmid.slot", int'(m_slot), 3);
        checkOutput("rstmid.overrun", int'(m_overrun), 0);
        for (int c = 0; c < 4; c++) begin
            checkOutput("rstmid.nodone", int'(m_done), 0);
            stepCycle();
        end
        checkDrives("rstmid.hold", 96, 40, 64);

        // Normal sequence after the aborted one
        tick = 1'b1;
        inc  = 3'b100;
        stepCycle();
        tick = 1'b0;
        inc  = 3'b000;
        repeat (3) stepCycle();
        checkOutput("post.k3.done", int'(m_done), 1);
        checkDrives("post.k3", 96, 40, 65);
        stepCycle();
        checkOutput("post.k4.busy", int'(m_busy), 0);
        checkOutput("post.k4.done", int'(m_done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
